// File: rtl/afu_tlx_pkg.sv
// Shared AFU/TLX command definitions: opcodes, dl encodings, credit widths and beat math.
package afu_tlx_pkg;

   localparam int unsigned CMD_CRED_W  = 4;
   localparam int unsigned DATA_CRED_W = 6;
   localparam int unsigned BEAT_W      = 3;

   localparam logic [7:0] OPC_NOP         = 8'h00;
   localparam logic [7:0] OPC_RD_WNITC    = 8'h10;
   localparam logic [7:0] OPC_PR_RD_WNITC = 8'h12;
   localparam logic [7:0] OPC_DMA_W       = 8'h20;
   localparam logic [7:0] OPC_DMA_PR_W    = 8'h24;

   localparam logic [1:0] DL_PARTIAL = 2'b00;
   localparam logic [1:0] DL_64B     = 2'b01;
   localparam logic [1:0] DL_128B    = 2'b10;
   localparam logic [1:0] DL_256B    = 2'b11;

   typedef struct packed {
      logic [7:0]  opcode;
      logic [15:0] afutag;
      logic [11:0] actag;
      logic [67:0] ea;
      logic [1:0]  dl;
      logic [2:0]  pl;
   } tlx_cmd_t;

   typedef struct packed {
      logic         bdi;
      logic [511:0] bus;
   } tlx_cdata_t;

   function automatic logic [BEAT_W-1:0] dl_to_beats(input logic [1:0] dl);
      case (dl)
         DL_128B: return BEAT_W'(2);
         DL_256B: return BEAT_W'(4);
         default: return BEAT_W'(1);
      endcase
   endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Round-robin picker: first eligible index at or after rr_ptr, wrapping modulo NREQ.
module rr_arb_pick
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  eligible,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] grant_idx
);

   int unsigned idx;
   logic        found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(rr_ptr) + k) % NREQ;
         if (!found && eligible[IDX_W'(idx)]) begin
            found                = 1'b1;
            grant[IDX_W'(idx)]   = 1'b1;
            grant_idx            = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/afu_tlx_cmd_arb.sv
// Shares the AFU->TLX command/data port among NREQ requesters with round-robin
// arbitration; a command issues only when its command and all data credits are available.
module afu_tlx_cmd_arb
   import afu_tlx_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDX_W = $clog2(NREQ)
) (
   input  logic                   clock_afu,
   input  logic                   reset,
   input  logic [2:0]             tlx_afu_cmd_resp_initial_credit,
   input  logic [4:0]             tlx_afu_data_initial_credit,
   input  logic                   tlx_afu_cmd_credit,
   input  logic                   tlx_afu_cmd_data_credit,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*8-1:0]      req_opcode,
   input  logic [NREQ*16-1:0]     req_afutag,
   input  logic [NREQ*12-1:0]     req_actag,
   input  logic [NREQ*68-1:0]     req_ea,
   input  logic [NREQ*2-1:0]      req_dl,
   input  logic [NREQ*3-1:0]      req_pl,
   input  logic [NREQ-1:0]        req_has_data,
   input  logic [NREQ*512-1:0]    req_cdata_bus,
   input  logic [NREQ-1:0]        req_cdata_bdi,
   output logic [NREQ-1:0]        req_ack,
   output logic [NREQ-1:0]        req_cdata_ack,
   output logic                   afu_tlx_cmd_valid,
   output logic [7:0]             afu_tlx_cmd_opcode,
   output logic [15:0]            afu_tlx_cmd_afutag,
   output logic [11:0]            afu_tlx_cmd_actag,
   output logic [67:0]            afu_tlx_cmd_ea_or_obj,
   output logic [1:0]             afu_tlx_cmd_dl,
   output logic [2:0]             afu_tlx_cmd_pl,
   output logic                   afu_tlx_cdata_valid,
   output logic                   afu_tlx_cdata_bdi,
   output logic [511:0]           afu_tlx_cdata_bus,
   output logic [CMD_CRED_W-1:0]  cmd_credits,
   output logic [DATA_CRED_W-1:0] data_credits,
   output logic                   credit_overflow
);

   localparam int unsigned            CMD_SUM_W     = CMD_CRED_W + 1;
   localparam int unsigned            DATA_SUM_W    = DATA_CRED_W + 1;
   localparam logic [CMD_CRED_W-1:0]  CMD_CRED_MAX  = '1;
   localparam logic [DATA_CRED_W-1:0] DATA_CRED_MAX = '1;

   typedef enum logic {ST_IDLE, ST_DATA} state_t;

   state_t                state, next_state;
   tlx_cmd_t              req_cmd   [NREQ];
   tlx_cdata_t            req_cd    [NREQ];
   logic [BEAT_W-1:0]     req_beats [NREQ];
   logic [NREQ-1:0]       eligible, pick;
   logic [IDX_W-1:0]      pick_idx, rr_ptr, owner;
   logic [BEAT_W-1:0]     beat_cnt, data_cons;
   logic                  grant_fire;
   tlx_cmd_t              sel_cmd;
   logic [CMD_SUM_W-1:0]  cmd_sum;
   logic [DATA_SUM_W-1:0] data_sum;

   // Unpack requester buses and qualify each requester against current credits.
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         req_cmd[i] = '{opcode: req_opcode[8*i +: 8],  afutag: req_afutag[16*i +: 16],
                        actag:  req_actag[12*i +: 12], ea:     req_ea[68*i +: 68],
                        dl:     req_dl[2*i +: 2],      pl:     req_pl[3*i +: 3]};
         req_cd[i]    = '{bdi: req_cdata_bdi[i], bus: req_cdata_bus[512*i +: 512]};
         req_beats[i] = dl_to_beats(req_dl[2*i +: 2]);
         eligible[i]  = req_valid[i] && (cmd_credits != '0) &&
                        (!req_has_data[i] || (data_credits >= DATA_CRED_W'(req_beats[i])));
      end
   end

   rr_arb_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
      .eligible  (eligible),
      .rr_ptr    (rr_ptr),
      .grant     (pick),
      .grant_idx (pick_idx)
   );

   always_ff @(posedge clock_afu) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Acks are combinational so the requester sees them in the grant/beat cycle itself.
   always_comb begin
      next_state    = state;
      grant_fire    = 1'b0;
      req_ack       = '0;
      req_cdata_ack = '0;
      data_cons     = '0;
      if (!reset) begin
         case (state)
            ST_IDLE: begin
               if (|pick) begin
                  grant_fire = 1'b1;
                  req_ack    = pick;
                  if (req_has_data[pick_idx]) begin
                     data_cons  = req_beats[pick_idx];
                     next_state = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               req_cdata_ack[owner] = 1'b1;
               if (beat_cnt == BEAT_W'(1)) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      sel_cmd  = grant_fire ? req_cmd[pick_idx] : '0;
      cmd_sum  = CMD_SUM_W'(cmd_credits) + CMD_SUM_W'(tlx_afu_cmd_credit) - CMD_SUM_W'(grant_fire);
      data_sum = DATA_SUM_W'(data_credits) + DATA_SUM_W'(tlx_afu_cmd_data_credit)
                 - DATA_SUM_W'(data_cons);
   end

   always_ff @(posedge clock_afu) begin
      if (reset) begin
         rr_ptr              <= '0;
         owner               <= '0;
         beat_cnt            <= '0;
         cmd_credits         <= {1'b0, tlx_afu_cmd_resp_initial_credit};
         data_credits        <= {1'b0, tlx_afu_data_initial_credit};
         credit_overflow     <= 1'b0;
         afu_tlx_cmd_valid   <= 1'b0;
         {afu_tlx_cmd_opcode, afu_tlx_cmd_afutag, afu_tlx_cmd_actag,
          afu_tlx_cmd_ea_or_obj, afu_tlx_cmd_dl, afu_tlx_cmd_pl} <= '0;
         afu_tlx_cdata_valid <= 1'b0;
         afu_tlx_cdata_bdi   <= 1'b0;
         afu_tlx_cdata_bus   <= '0;
      end else begin
         // A return that cannot be absorbed is lost and flagged.
         if (cmd_sum > CMD_SUM_W'(CMD_CRED_MAX)) begin
            cmd_credits     <= CMD_CRED_MAX;
            credit_overflow <= 1'b1;
         end else begin
            cmd_credits <= cmd_sum[CMD_CRED_W-1:0];
         end
         if (data_sum > DATA_SUM_W'(DATA_CRED_MAX)) begin
            data_credits    <= DATA_CRED_MAX;
            credit_overflow <= 1'b1;
         end else begin
            data_credits <= data_sum[DATA_CRED_W-1:0];
         end

         afu_tlx_cmd_valid <= grant_fire;
         {afu_tlx_cmd_opcode, afu_tlx_cmd_afutag, afu_tlx_cmd_actag,
          afu_tlx_cmd_ea_or_obj, afu_tlx_cmd_dl, afu_tlx_cmd_pl} <= sel_cmd;
         if (grant_fire) begin
            rr_ptr <= (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + IDX_W'(1);
            if (req_has_data[pick_idx]) begin
               owner    <= pick_idx;
               beat_cnt <= req_beats[pick_idx];
            end
         end

         if (state == ST_DATA) begin
            beat_cnt            <= beat_cnt - BEAT_W'(1);
            afu_tlx_cdata_valid <= 1'b1;
            afu_tlx_cdata_bdi   <= req_cd[owner].bdi;
            afu_tlx_cdata_bus   <= req_cd[owner].bus;
         end else begin
            afu_tlx_cdata_valid <= 1'b0;
            afu_tlx_cdata_bdi   <= 1'b0;
            afu_tlx_cdata_bus   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_afu_tlx_cmd_arb.sv
// Bench for afu_tlx_cmd_arb: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue/arithmetic reference model.
module tb_afu_tlx_cmd_arb;

   localparam int NREQ = 4;

   logic            clock_afu = 1'b0;
   logic            reset = 1'b1;
   logic [2:0]      init_cmd = 3'd0;
   logic [4:0]      init_data = 5'd0;
   logic            cmd_ret = 1'b0, data_ret = 1'b0;
   logic [NREQ-1:0] req_valid, req_has_data, req_cdata_bdi;
   logic [NREQ*8-1:0]   req_opcode;
   logic [NREQ*16-1:0]  req_afutag;
   logic [NREQ*12-1:0]  req_actag;
   logic [NREQ*68-1:0]  req_ea;
   logic [NREQ*2-1:0]   req_dl;
   logic [NREQ*3-1:0]   req_pl;
   logic [NREQ*512-1:0] req_cdata_bus;
   logic [NREQ-1:0] req_ack, req_cdata_ack;
   logic            cmd_valid, cdata_valid, cdata_bdi, credit_overflow;
   logic [7:0]      cmd_opcode;
   logic [15:0]     cmd_afutag;
   logic [11:0]     cmd_actag;
   logic [67:0]     cmd_ea;
   logic [1:0]      cmd_dl;
   logic [2:0]      cmd_pl;
   logic [511:0]    cdata_bus;
   logic [3:0]      cmd_credits;
   logic [5:0]      data_credits;

   int n_vec = 0;
   int n_err = 0;

   afu_tlx_cmd_arb #(.NREQ(NREQ)) dut (
      .clock_afu                       (clock_afu),
      .reset                           (reset),
      .tlx_afu_cmd_resp_initial_credit (init_cmd),
      .tlx_afu_data_initial_credit     (init_data),
      .tlx_afu_cmd_credit              (cmd_ret),
      .tlx_afu_cmd_data_credit         (data_ret),
      .req_valid                       (req_valid),
      .req_opcode                      (req_opcode),
      .req_afutag                      (req_afutag),
      .req_actag                       (req_actag),
      .req_ea                          (req_ea),
      .req_dl                          (req_dl),
      .req_pl                          (req_pl),
      .req_has_data                    (req_has_data),
      .req_cdata_bus                   (req_cdata_bus),
      .req_cdata_bdi                   (req_cdata_bdi),
      .req_ack                         (req_ack),
      .req_cdata_ack                   (req_cdata_ack),
      .afu_tlx_cmd_valid               (cmd_valid),
      .afu_tlx_cmd_opcode              (cmd_opcode),
      .afu_tlx_cmd_afutag              (cmd_afutag),
      .afu_tlx_cmd_actag               (cmd_actag),
      .afu_tlx_cmd_ea_or_obj           (cmd_ea),
      .afu_tlx_cmd_dl                  (cmd_dl),
      .afu_tlx_cmd_pl                  (cmd_pl),
      .afu_tlx_cdata_valid             (cdata_valid),
      .afu_tlx_cdata_bdi               (cdata_bdi),
      .afu_tlx_cdata_bus               (cdata_bus),
      .cmd_credits                     (cmd_credits),
      .data_credits                    (data_credits),
      .credit_overflow                 (credit_overflow)
   );

   always #5 clock_afu = ~clock_afu;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic int beats_of(input logic [1:0] dl);
      return (dl == 2'b11) ? 4 : (dl == 2'b10) ? 2 : 1;
   endfunction

   function automatic logic [511:0] pat(input int k);
      return {16{32'hB0B0_0000 + 32'(k)}};
   endfunction

   // Reference model: credits as integers, a rotating start index, a beats-left counter.
   int              m_cmd, m_data, m_ptr, m_owner, m_left;
   bit              m_ovf, m_ready;
   logic            e_cmd_valid, e_cd_valid, e_cd_bdi;
   logic [108:0]    e_cmd;
   logic [511:0]    e_cd_bus;

   always @(negedge clock_afu) begin : model
      int gi, b, nc, nd, idx;
      logic [NREQ-1:0] e_ack, e_cdack;
      e_ack = '0; e_cdack = '0; gi = -1; b = 0;
      if (!reset) begin
         if (m_left > 0) e_cdack[m_owner] = 1'b1;
         else begin
            for (int k = 0; k < NREQ; k++) begin
               idx = (m_ptr + k) % NREQ;
               if (gi < 0 && req_valid[idx] && m_cmd >= 1 &&
                   (!req_has_data[idx] || m_data >= beats_of(req_dl[2*idx +: 2])))
                  gi = idx;
            end
            if (gi >= 0) e_ack[gi] = 1'b1;
         end
      end
      if (m_ready) begin
         chk("req_ack", 64'(req_ack), 64'(e_ack));
         chk("req_cdata_ack", 64'(req_cdata_ack), 64'(e_cdack));
         chk("cmd_valid", 64'(cmd_valid), 64'(e_cmd_valid));
         chkw("cmd_fields", 512'({cmd_opcode, cmd_afutag, cmd_actag, cmd_ea, cmd_dl, cmd_pl}), 512'(e_cmd));
         chk("cdata_valid", 64'(cdata_valid), 64'(e_cd_valid));
         chk("cdata_bdi", 64'(cdata_bdi), 64'(e_cd_bdi));
         chkw("cdata_bus", cdata_bus, e_cd_bus);
         chk("cmd_credits", 64'(cmd_credits), 64'(m_cmd));
         chk("data_credits", 64'(data_credits), 64'(m_data));
         chk("credit_overflow", 64'(credit_overflow), 64'(m_ovf));
      end
      if (reset) begin
         m_cmd = int'(init_cmd); m_data = int'(init_data);
         m_ovf = 0; m_ptr = 0; m_left = 0; m_owner = 0;
         e_cmd_valid = 0; e_cmd = '0; e_cd_valid = 0; e_cd_bdi = 0; e_cd_bus = '0;
         m_ready = 1;
      end else if (m_ready) begin
         if (m_left > 0) begin
            e_cd_valid = 1'b1;
            e_cd_bus   = req_cdata_bus[512*m_owner +: 512];
            e_cd_bdi   = req_cdata_bdi[m_owner];
            m_left--;
         end else begin
            e_cd_valid = 1'b0; e_cd_bus = '0; e_cd_bdi = 1'b0;
         end
         e_cmd_valid = (gi >= 0);
         e_cmd = '0;
         if (gi >= 0) begin
            e_cmd = {req_opcode[8*gi +: 8], req_afutag[16*gi +: 16], req_actag[12*gi +: 12],
                     req_ea[68*gi +: 68], req_dl[2*gi +: 2], req_pl[3*gi +: 3]};
            if (req_has_data[gi]) b = beats_of(req_dl[2*gi +: 2]);
         end
         nc = m_cmd + int'(cmd_ret) - ((gi >= 0) ? 1 : 0);
         nd = m_data + int'(data_ret) - b;
         if (nc > 15) begin nc = 15; m_ovf = 1; end
         if (nd > 63) begin nd = 63; m_ovf = 1; end
         m_cmd = nc; m_data = nd;
         if (gi >= 0) begin
            m_ptr = (gi + 1) % NREQ;
            if (req_has_data[gi]) begin m_owner = gi; m_left = b; end
         end
      end
   end

   task automatic next();
      @(posedge clock_afu); #1;
   endtask

   task automatic mid();
      @(negedge clock_afu);
   endtask

   task automatic clear_reqs();
      req_valid = '0; req_has_data = '0; req_cdata_bdi = '0; req_opcode = '0;
      req_afutag = '0; req_actag = '0; req_ea = '0; req_dl = '0; req_pl = '0;
      req_cdata_bus = '0;
   endtask

   task automatic set_req(input int i, input bit hd, input logic [1:0] dl, input logic [15:0] tag);
      req_valid[i]             = 1'b1;
      req_has_data[i]          = hd;
      req_dl[2*i +: 2]         = dl;
      req_afutag[16*i +: 16]   = tag;
      req_opcode[8*i +: 8]     = hd ? 8'h20 : 8'h10;
      req_actag[12*i +: 12]    = 12'(i + 1);
      req_ea[68*i +: 68]       = {4'h0, 32'(i), 32'hC0DE_0000};
      req_pl[3*i +: 3]         = 3'(i);
   endtask

   task automatic do_reset(input logic [2:0] c, input logic [4:0] d);
      reset = 1'b1; init_cmd = c; init_data = d; cmd_ret = 0; data_ret = 0;
      clear_reqs();
      repeat (2) next();
      reset = 1'b0;
   endtask

   initial begin
      clear_reqs();

      // Reads consume command credits; the fourth waits for a return.
      do_reset(3'd3, 5'd4);
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 2'b01, 16'hA000 + 16'(i));
      mid(); chk("t1_init_cmd", 64'(cmd_credits), 64'd3); chk("t1_ack0", 64'(req_ack), 64'b0001);
      next(); mid(); chk("t1_ack1", 64'(req_ack), 64'b0010);
      chk("t1_cmd_valid", 64'(cmd_valid), 64'd1); chk("t1_afutag", 64'(cmd_afutag), 64'hA000);
      next(); mid(); chk("t1_ack2", 64'(req_ack), 64'b0100);
      next(); cmd_ret = 1'b1;
      mid(); chk("t1_blocked", 64'(req_ack), 64'd0); chk("t1_cred0", 64'(cmd_credits), 64'd0);
      next(); cmd_ret = 1'b0;
      mid(); chk("t1_ack3", 64'(req_ack), 64'b1000);

      // 4-beat write waits for its last data credit, then streams beats.
      do_reset(3'd7, 5'd3);
      set_req(1, 1'b1, 2'b11, 16'h0B01);
      data_ret = 1'b1;
      mid(); chk("t2_blocked", 64'(req_ack), 64'd0); chk("t2_dcred3", 64'(data_credits), 64'd3);
      next(); data_ret = 1'b0;
      mid(); chk("t2_grant", 64'(req_ack), 64'b0010); chk("t2_dcred4", 64'(data_credits), 64'd4);
      next(); req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         req_cdata_bus[512*1 +: 512] = pat(k);
         mid();
         chk("t2_cdack", 64'(req_cdata_ack), 64'b0010);
         if (k == 0) begin
            chk("t2_dcred0", 64'(data_credits), 64'd0);
            chk("t2_ccred6", 64'(cmd_credits), 64'd6);
         end else begin
            chkw("t2_beat", cdata_bus, pat(k - 1));
         end
         next();
      end
      mid(); chk("t2_last_valid", 64'(cdata_valid), 64'd1); chkw("t2_beat3", cdata_bus, pat(3));
      next(); mid(); chk("t2_done", 64'(cdata_valid), 64'd0);

      // Fairness, with a return every cycle netting out each consumed credit.
      do_reset(3'd7, 5'd31);
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 2'b00, 16'hC000 + 16'(i));
      cmd_ret = 1'b1;
      for (int g = 0; g < 8; g++) begin
         mid();
         chk("t3_order", 64'(req_ack), 64'(1 << (g % NREQ)));
         chk("t3_net_cred", 64'(cmd_credits), 64'd7);
         next();
      end

      // Saturation and sticky overflow.
      do_reset(3'd7, 5'd0);
      cmd_ret = 1'b1;
      repeat (10) next();
      cmd_ret = 1'b0;
      mid(); chk("t5_sat", 64'(cmd_credits), 64'd15); chk("t5_ovf", 64'(credit_overflow), 64'd1);
      repeat (3) next();
      mid(); chk("t5_ovf_sticky", 64'(credit_overflow), 64'd1);

      // Reset in the middle of a 4-beat write.
      do_reset(3'd5, 5'd20);
      set_req(2, 1'b1, 2'b11, 16'h0D02);
      mid(); chk("t6_ovf_clr", 64'(credit_overflow), 64'd0); chk("t6_grant", 64'(req_ack), 64'b0100);
      next(); req_valid = '0;
      mid(); chk("t6_beat1", 64'(req_cdata_ack), 64'b0100);
      next(); reset = 1'b1;
      mid(); chk("t6_rst_cdack", 64'(req_cdata_ack), 64'd0);
      next(); reset = 1'b0; set_req(0, 1'b0, 2'b01, 16'h0E00);
      mid(); chk("t6_cdv0", 64'(cdata_valid), 64'd0); chk("t6_ccred", 64'(cmd_credits), 64'd5);
      chk("t6_dcred", 64'(data_credits), 64'd20); chk("t6_regrant", 64'(req_ack), 64'b0001);
      next(); mid(); chk("t6_cmd", 64'(cmd_valid), 64'd1); chk("t6_tag", 64'(cmd_afutag), 64'h0E00);

      // Randomized traffic; returns withheld near saturation so the model's cases stay unambiguous.
      do_reset(3'($urandom), 5'($urandom));
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         if (reset) begin init_cmd = 3'($urandom); init_data = 5'($urandom); end
         req_valid = 4'($urandom); req_has_data = 4'($urandom); req_cdata_bdi = 4'($urandom);
         req_dl = 8'($urandom); req_pl = 12'($urandom); req_opcode = $urandom;
         req_afutag = {$urandom, $urandom}; req_actag = {16'($urandom), $urandom};
         for (int w = 0; w < 9; w++) req_ea[32*w +: 32] = $urandom;
         for (int w = 0; w < 64; w++) req_cdata_bus[32*w +: 32] = $urandom;
         cmd_ret  = ($urandom_range(0, 2) == 0) && (m_cmd < 14);
         data_ret = ($urandom_range(0, 1) == 0) && (m_data < 60);
         next();
      end
      reset = 1'b0; clear_reqs(); cmd_ret = 0; data_ret = 0;
      next(); mid();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/afu_tlx_cmd_arb.md
# afu_tlx_cmd_arb

Round-robin arbiter and credit manager that shares the single AFU-to-TLX command transmit interface (afu_tlx_cmd_* / afu_tlx_cdata_*) among NREQ internal command requesters. It tracks TLX command and command-data credits (initial load plus tlx_afu_cmd_credit / tlx_afu_cmd_data_credit returns). A command is issued only when it and all its data beats are fully covered by credits. It sits inside the AFU top, between the engines and the TLX port.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDX_W, $clog2(NREQ), requester index width
- clock_afu  in  1  AFU clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- tlx_afu_cmd_resp_initial_credit  in  3  initial command credits, sampled every reset cycle
- tlx_afu_data_initial_credit  in  5  initial data credits, sampled every reset cycle
- tlx_afu_cmd_credit  in  1  one command credit returned per cycle high
- tlx_afu_cmd_data_credit  in  1  one data credit returned per cycle high
- req_valid  in  NREQ  requester i has a command pending
- req_opcode  in  NREQ*8  per-requester opcode, slice i = [8i+7:8i]
- req_afutag  in  NREQ*16  per-requester afutag
- req_actag  in  NREQ*12  per-requester actag
- req_ea  in  NREQ*68  per-requester ea_or_obj
- req_dl  in  NREQ*2  per-requester dl
- req_pl  in  NREQ*3  per-requester pl
- req_has_data  in  NREQ  command carries write data
- req_cdata_bus  in  NREQ*512  per-requester data beat
- req_cdata_bdi  in  NREQ  per-requester bad-data indicator
- req_ack  out  NREQ  one-hot pulse: command of requester i accepted
- req_cdata_ack  out  NREQ  one-hot pulse: current beat of requester i consumed
- afu_tlx_cmd_valid, afu_tlx_cmd_opcode[7:0], afu_tlx_cmd_afutag[15:0], afu_tlx_cmd_actag[11:0], afu_tlx_cmd_ea_or_obj[67:0], afu_tlx_cmd_dl[1:0], afu_tlx_cmd_pl[2:0]  out  registered command to TLX
- afu_tlx_cdata_valid, afu_tlx_cdata_bdi, afu_tlx_cdata_bus[511:0]  out  registered data beat to TLX
- cmd_credits  out  4  current command credit count
- data_credits  out  6  current data credit count
- credit_overflow  out  1  sticky: a credit return arrived while the counter was saturated

## Operation
- Beats per write: dl 2'b00 -> 1 (partial), 2'b01 -> 1, 2'b10 -> 2, 2'b11 -> 4. A non-data command needs 0 beats.
- Eligible(i) = req_valid[i] && cmd_credits >= 1 && (!req_has_data[i] || data_credits >= beats(i)).
- FSM states:
  - IDLE:
    - Pick the first eligible index starting at rr_ptr and wrapping modulo NREQ.
    - Pulse req_ack[i]. Register the fields of requester i onto afu_tlx_cmd_*.
    - Decrement cmd_credits by 1 and data_credits by beats(i).
    - Set rr_ptr = (i+1) mod NREQ.
    - If req_has_data[i], latch owner=i and beat_cnt=beats(i), then go to DATA. Otherwise stay in IDLE; a grant is possible every cycle.
  - DATA:
    - Each cycle pulse req_cdata_ack[owner] and register req_cdata_bus/bdi[owner] onto afu_tlx_cdata_*.
    - Decrement beat_cnt; on the last beat return to IDLE.
    - No grants are made in DATA.
- Requesters must present beat k in the cycle req_cdata_ack is returned for beat k. There is no data stall.
- Credit counters:
  - During reset, each cycle load cmd_credits = {1'b0, initial_cmd} and data_credits = {1'b0, initial_data}.
  - Afterwards, next = cur + return - consumed, with a simultaneous return and consume in the same cycle netting out.
  - Saturate at 15 / 63. A return while saturated sets credit_overflow, which clears only on reset.
- No eligible requester: hold, outputs idle. A requester lacking credits does not block other eligible requesters.

## Timing
- Reset values: all outputs 0, rr_ptr=0, state IDLE, beat_cnt=0.
- Reset mid-DATA aborts the transfer. Owner and beats are discarded and counters reload.
- Command: req_ack[i] in cycle N -> afu_tlx_cmd_valid in cycle N+1 for exactly one cycle.
- Data: the first req_cdata_ack is in cycle N+1, so the first afu_tlx_cdata_valid is in cycle N+2. Beats are consecutive.
- Credits returned in cycle N count toward eligibility in cycle N+1.
- Back-to-back write: the next grant can occur in the cycle after the last DATA cycle.

## Structure
- Shared package afu_tlx_pkg holds:
  - opcode localparams
  - dl encodings
  - function dl_to_beats(dl) returning 3 bits
  - credit counter widths CMD_CRED_W=4 and DATA_CRED_W=6
- One sub-module: rr_arb_pick (NREQ, IDX_W). Inputs are eligible vector and rr_ptr; outputs are one-hot grant and grant index (combinational).
- Credit counters and the FSM live in the top.

## Test plan
- Reset with initial_cmd=3, initial_data=4; three requesters issue reads -> three cmd_valid pulses, cmd_credits=0, and the fourth is blocked until a tlx_afu_cmd_credit pulse.
- Requester 1 writes dl=2'b11 with data_credits=3 -> not granted. One tlx_afu_cmd_data_credit pulse -> granted; 4 consecutive cdata beats with matching bus values; data_credits=0.
- All 4 requesters continuously valid with reads and ample credits -> grant order 0,1,2,3,0 and no requester starved.
- In the same cycle, a grant consumes 1 cmd credit and tlx_afu_cmd_credit returns 1 -> cmd_credits unchanged.
- cmd_credits=15 plus a return pulse -> counter stays at 15 and credit_overflow=1 until reset.
- Assert reset during beat 2 of a 4-beat write -> next cycle cdata_valid=0 and counters equal the initial inputs. Recovery issues new grants normally.
